vga_sync_gen: RTL and testbench

//  Timing source for the VGA display path. Divides clk into a pixel enable
//  and scans the raster (x, y). Produces vid_on, hsync and vsync, plus a

---
 rtl/vga_sync_gen_pkg.sv | 30 +++
 rtl/vga_sync_gen_if.sv | 31 +++
 rtl/vga_sync_gen_sig_delay.sv | 37 +++
 rtl/vga_sync_gen.sv | 116 +++++++++++
 tb/tb_vga_sync_gen.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_sync_gen_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vga_sync_gen_pkg : VGA 640x480@60 timing defaults, shared widths |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
package vga_sync_gen_pkg;

  localparam int COLOUR_W = 12;
  localparam int COORD_W  = 10;

  localparam int H_DISPLAY_D = 640;
  localparam int H_FRONT_D   = 16;
  localparam int H_SYNC_D    = 96;
  localparam int H_BACK_D    = 48;
  localparam int V_DISPLAY_D = 480;
  localparam int V_FRONT_D   = 10;
  localparam int V_SYNC_D    = 2;
  localparam int V_BACK_D    = 33;

  localparam int H_TOTAL_D = H_DISPLAY_D + H_FRONT_D + H_SYNC_D + H_BACK_D;
  localparam int V_TOTAL_D = V_DISPLAY_D + V_FRONT_D + V_SYNC_D + V_BACK_D;

  function automatic logic in_window(input logic [COORD_W-1:0] v,
                                     input logic [COORD_W-1:0] lo,
                                     input logic [COORD_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_sync_gen_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vga_sync_gen_if : raster/colour bus between timing gen and video |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
interface vga_sync_gen_if
  import vga_sync_gen_pkg::*;
();

  logic [COLOUR_W-1:0] rgb_in;
  logic [COORD_W-1:0]  x;
  logic [COORD_W-1:0]  y;
  logic                vid_on;
  logic                p_tick;
  logic                frame_tick;
  logic                hsync;
  logic                vsync;
  logic [COLOUR_W-1:0] vga_rgb;

  modport master (
    input  rgb_in,
    output x, y, vid_on, p_tick, frame_tick, hsync, vsync, vga_rgb
  );

  modport slave (
    output rgb_in,
    input  x, y, vid_on, p_tick, frame_tick, hsync, vsync, vga_rgb
  );

endinterface
`default_nettype wire

// File: rtl/vga_sync_gen_sig_delay.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sig_delay : generic shift register with synchronous active-low   |
// | reset to RST_VAL; rev 1.0                                        |
// +------------------------------------------------------------------+
module sig_delay #(
  parameter int                WIDTH   = 1,
  parameter int                DEPTH   = 1,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic [WIDTH-1:0] i_d,
  output      logic [WIDTH-1:0] o_q
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign o_q = i_d;
    end else begin : g_shift
      logic [WIDTH-1:0] r_stage [DEPTH];

      always_ff @(posedge clk) begin
        if (!reset) begin
          for (int i = 0; i < DEPTH; i++) r_stage[i] <= RST_VAL;
        end else begin
          r_stage[0] <= i_d;
          for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
      end

      assign o_q = r_stage[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vga_sync_gen : pixel divider, raster counters, sync decode and   |
// | renderer-aligned output stage; rev 1.0                           |
// +------------------------------------------------------------------+
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = H_DISPLAY_D,
  parameter int H_FRONT   = H_FRONT_D,
  parameter int H_SYNC    = H_SYNC_D,
  parameter int H_BACK    = H_BACK_D,
  parameter int V_DISPLAY = V_DISPLAY_D,
  parameter int V_FRONT   = V_FRONT_D,
  parameter int V_SYNC    = V_SYNC_D,
  parameter int V_BACK    = V_BACK_D,
  parameter bit SYNC_POL  = 1'b0,
  parameter int PIPE_DLY  = 1
) (
  input  wire logic      clk,
  input  wire logic      reset,
  vga_sync_gen_if.master bus
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]   c_div_last = DIV_W'(CLK_DIV - 1);
  localparam logic [COORD_W-1:0] c_x_last   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] c_y_last   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] c_h_disp   = COORD_W'(H_DISPLAY);
  localparam logic [COORD_W-1:0] c_v_disp   = COORD_W'(V_DISPLAY);
  localparam logic [COORD_W-1:0] c_hs_start = COORD_W'(H_DISPLAY + H_FRONT);
  localparam logic [COORD_W-1:0] c_hs_end   = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [COORD_W-1:0] c_vs_start = COORD_W'(V_DISPLAY + V_FRONT);
  localparam logic [COORD_W-1:0] c_vs_end   = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0]    r_div;
  logic [COORD_W-1:0]  r_x, r_y;
  logic                r_vid_on, r_hs_raw, r_vs_raw, r_p_tick, r_frame_tick;
  logic                r_hsync, r_vsync;
  logic [COLOUR_W-1:0] r_rgb;

  logic                w_div_last, w_x_wrap;
  logic [COORD_W-1:0]  w_x_next, w_y_next;
  logic [2:0]          w_dly;

  always_comb begin
    w_div_last = (r_div == c_div_last);
    w_x_wrap   = w_div_last && (r_x == c_x_last);
    w_x_next   = r_x;
    w_y_next   = r_y;
    if (w_div_last) w_x_next = w_x_wrap ? '0 : r_x + COORD_W'(1);
    if (w_x_wrap)   w_y_next = (r_y == c_y_last) ? '0 : r_y + COORD_W'(1);
  end

  // Decode from the next counter values so flags line up with x/y every clk.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_div        <= '0;
      r_x          <= c_x_last;
      r_y          <= c_y_last;
      r_vid_on     <= 1'b0;
      r_hs_raw     <= ~SYNC_POL;
      r_vs_raw     <= ~SYNC_POL;
      r_p_tick     <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_div        <= w_div_last ? '0 : r_div + DIV_W'(1);
      r_x          <= w_x_next;
      r_y          <= w_y_next;
      r_vid_on     <= (w_x_next < c_h_disp) && (w_y_next < c_v_disp);
      r_hs_raw     <= in_window(w_x_next, c_hs_start, c_hs_end) ? SYNC_POL : ~SYNC_POL;
      r_vs_raw     <= in_window(w_y_next, c_vs_start, c_vs_end) ? SYNC_POL : ~SYNC_POL;
      r_p_tick     <= w_div_last;
      r_frame_tick <= w_x_wrap && (r_y == c_y_last);
    end
  end

  sig_delay #(
    .WIDTH   (3),
    .DEPTH   (PIPE_DLY),
    .RST_VAL ({1'b0, ~SYNC_POL, ~SYNC_POL})
  ) u_dly (
    .clk   (clk),
    .reset (reset),
    .i_d   ({r_vid_on, r_hs_raw, r_vs_raw}),
    .o_q   (w_dly)
  );

  // Sync shares the colour register stage so connector pins switch together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hsync <= ~SYNC_POL;
      r_vsync <= ~SYNC_POL;
      r_rgb   <= '0;
    end else begin
      r_hsync <= w_dly[1];
      r_vsync <= w_dly[0];
      r_rgb   <= w_dly[2] ? bus.rgb_in : '0;
    end
  end

  assign bus.x          = r_x;
  assign bus.y          = r_y;
  assign bus.vid_on     = r_vid_on;
  assign bus.p_tick     = r_p_tick;
  assign bus.frame_tick = r_frame_tick;
  assign bus.hsync      = r_hsync;
  assign bus.vsync      = r_vsync;
  assign bus.vga_rgb    = r_rgb;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | tb_vga_sync_gen : three timing configs against a raster model    |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_vga_sync_gen;
  import vga_sync_gen_pkg::*;

  typedef struct {
    int div; int hd; int hf; int hs; int hb;
    int vd; int vf; int vs; int vb; bit pol; int pipe;
  } cfg_t;

  typedef struct {
    int x; int y;
    logic vid; logic ptick; logic frame; logic hsync; logic vsync;
    logic [11:0] rgb;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_n = 3'b000;
  int checks = 0;
  int errors = 0;
  int n_m [3] = '{0, 0, 0};

  vga_sync_gen_if ifA ();
  vga_sync_gen_if ifB ();
  vga_sync_gen_if ifC ();

  vga_sync_gen #(.CLK_DIV(4), .H_DISPLAY(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
                 .V_DISPLAY(480), .V_FRONT(10), .V_SYNC(2), .V_BACK(33),
                 .SYNC_POL(1'b0), .PIPE_DLY(1))
    dutA (.clk(clk), .reset(rst_n[0]), .bus(ifA));

  vga_sync_gen #(.CLK_DIV(1), .H_DISPLAY(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
                 .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                 .SYNC_POL(1'b0), .PIPE_DLY(1))
    dutB (.clk(clk), .reset(rst_n[1]), .bus(ifB));

  vga_sync_gen #(.CLK_DIV(3), .H_DISPLAY(20), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                 .V_DISPLAY(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
                 .SYNC_POL(1'b1), .PIPE_DLY(2))
    dutC (.clk(clk), .reset(rst_n[2]), .bus(ifC));

  function automatic cfg_t get_cfg(input int id);
    cfg_t c;
    case (id)
      0:       c = '{4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1};
      1:       c = '{1, 8, 1, 2, 1, 4, 1, 1, 1, 1'b0, 1};
      default: c = '{3, 20, 2, 3, 2, 10, 2, 2, 3, 1'b1, 2};
    endcase
    return c;
  endfunction

  // Position after n clk since reset: the k-th pixel tick lands on raster index k-1.
  function automatic void raster(input cfg_t c, input int n, output int x, output int y);
    int htot = c.hd + c.hf + c.hs + c.hb;
    int tot  = htot * (c.vd + c.vf + c.vs + c.vb);
    int l    = (n / c.div - 1 + tot) % tot;
    x = l % htot;
    y = l / htot;
  endfunction

  function automatic void decode(input cfg_t c, input int m,
                                 output logic vid, output logic hs_act, output logic vs_act);
    int x, y;
    vid = 1'b0; hs_act = 1'b0; vs_act = 1'b0;
    if (m >= 0) begin
      raster(c, m, x, y);
      vid    = (x < c.hd) && (y < c.vd);
      hs_act = (x >= c.hd + c.hf) && (x < c.hd + c.hf + c.hs);
      vs_act = (y >= c.vd + c.vf) && (y < c.vd + c.vf + c.vs);
    end
  endfunction

  function automatic int drive_val(input int id, input int n);
    if (id == 0) return 'hFFF;
    return (n * 149 + id * 1000 + 7) % 4096;
  endfunction

  function automatic obs_t model(input int id, input int n);
    cfg_t c = get_cfg(id);
    obs_t o;
    logic vid, hs, vs, dv, dh, dvs;
    raster(c, n, o.x, o.y);
    decode(c, n, vid, hs, vs);
    o.vid   = vid;
    o.ptick = (n > 0) && (n % c.div == 0);
    o.frame = o.ptick && (o.x == 0) && (o.y == 0);
    decode(c, n - 1 - c.pipe, dv, dh, dvs);
    o.hsync = dh  ? c.pol : ~c.pol;
    o.vsync = dvs ? c.pol : ~c.pol;
    o.rgb   = (n >= 1 && dv) ? 12'(drive_val(id, n - 1)) : 12'h000;
    return o;
  endfunction

  function automatic obs_t sample(input int id);
    obs_t o;
    case (id)
      0: begin o.x = int'(ifA.x); o.y = int'(ifA.y); o.vid = ifA.vid_on; o.ptick = ifA.p_tick;
               o.frame = ifA.frame_tick; o.hsync = ifA.hsync; o.vsync = ifA.vsync; o.rgb = ifA.vga_rgb; end
      1: begin o.x = int'(ifB.x); o.y = int'(ifB.y); o.vid = ifB.vid_on; o.ptick = ifB.p_tick;
               o.frame = ifB.frame_tick; o.hsync = ifB.hsync; o.vsync = ifB.vsync; o.rgb = ifB.vga_rgb; end
      default: begin o.x = int'(ifC.x); o.y = int'(ifC.y); o.vid = ifC.vid_on; o.ptick = ifC.p_tick;
               o.frame = ifC.frame_tick; o.hsync = ifC.hsync; o.vsync = ifC.vsync; o.rgb = ifC.vga_rgb; end
    endcase
    return o;
  endfunction

  task automatic chk_obs(input string nm, input int n, input obs_t g, input obs_t e);
    checks++;
    if (g.x !== e.x || g.y !== e.y || g.vid !== e.vid || g.ptick !== e.ptick ||
        g.frame !== e.frame || g.hsync !== e.hsync || g.vsync !== e.vsync || g.rgb !== e.rgb) begin
      errors++;
      $display("FAIL %s n=%0d got x=%0d y=%0d vid=%b pt=%b ft=%b hs=%b vs=%b rgb=%h | expected x=%0d y=%0d vid=%b pt=%b ft=%b hs=%b vs=%b rgb=%h",
               nm, n, g.x, g.y, g.vid, g.ptick, g.frame, g.hsync, g.vsync, g.rgb,
               e.x, e.y, e.vid, e.ptick, e.frame, e.hsync, e.vsync, e.rgb);
    end
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Model compare on every clk, then drive the next renderer colour.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) n_m[i] = rst_n[i] ? n_m[i] + 1 : 0;
    #1;
    chk_obs("A_model", n_m[0], sample(0), model(0, n_m[0]));
    chk_obs("B_model", n_m[1], sample(1), model(1, n_m[1]));
    chk_obs("C_model", n_m[2], sample(2), model(2, n_m[2]));
    ifA.rgb_in = 12'(drive_val(0, n_m[0]));
    ifB.rgb_in = 12'(drive_val(1, n_m[1]));
    ifC.rgb_in = 12'(drive_val(2, n_m[2]));
  end

  initial begin
    int hs_lo, pt_cnt, vid_cnt, fff_cnt, prev_x, t;
    int b_pt, b_last, b_hs, c_last, c_vs, cyc;
    obs_t pin;

    // Hand-computed points that pin the model itself.
    pin = model(0, 4);
    chk("model_A_n4_x", pin.x, 0);
    chk("model_A_n4_frame", int'(pin.frame), 1);
    pin = model(0, 3204);
    chk("model_A_n3204_y", pin.y, 1);
    pin = model(1, 85);
    chk("model_B_n85_frame", int'(pin.frame), 1);

    repeat (5) @(negedge clk);
    chk("A_rst_x", int'(ifA.x), 799);
    chk("A_rst_y", int'(ifA.y), 524);
    chk("A_rst_vid", int'(ifA.vid_on), 0);
    chk("A_rst_hsync", int'(ifA.hsync), 1);
    chk("A_rst_vsync", int'(ifA.vsync), 1);
    chk("A_rst_ptick", int'(ifA.p_tick), 0);
    chk("A_rst_rgb", int'(ifA.vga_rgb), 0);
    chk("C_rst_hsync", int'(ifC.hsync), 0);
    chk("B_rst_xy", int'({ifB.x, ifB.y}), (11 << 10) | 6);

    rst_n = 3'b111;
    repeat (3) @(negedge clk);
    chk("A_pre_tick_x", int'(ifA.x), 799);
    chk("A_pre_tick_ptick", int'(ifA.p_tick), 0);
    @(negedge clk);
    chk("A_first_tick_x", int'(ifA.x), 0);
    chk("A_first_tick_y", int'(ifA.y), 0);
    chk("A_first_tick_vid", int'(ifA.vid_on), 1);
    chk("A_first_tick_frame", int'(ifA.frame_tick), 1);
    chk("A_first_tick_ptick", int'(ifA.p_tick), 1);
    @(negedge clk);
    chk("A_frame_one_clk", int'(ifA.frame_tick), 0);

    hs_lo = 0; pt_cnt = 0; vid_cnt = 0; fff_cnt = 0; prev_x = int'(ifA.x);
    b_pt = 0; b_last = -1; b_hs = 0; c_last = -1; c_vs = 0;
    for (cyc = 0; cyc < 3200; cyc++) begin
      @(negedge clk);
      hs_lo   += (ifA.hsync == 1'b0) ? 1 : 0;
      pt_cnt  += int'(ifA.p_tick);
      vid_cnt += int'(ifA.vid_on);
      fff_cnt += (ifA.vga_rgb == 12'hFFF) ? 1 : 0;
      if (prev_x == 639 && ifA.x == 10'd640) chk("A_vid_drop_at_640", int'(ifA.vid_on), 0);
      prev_x = int'(ifA.x);
      b_pt += int'(ifB.p_tick);
      if (ifB.frame_tick) begin
        if (b_last >= 0) begin
          chk("B_frame_period", cyc - b_last, 84);
          chk("B_hsync_low_per_frame", b_hs, 14);
        end
        b_last = cyc; b_hs = 0;
      end
      b_hs += (ifB.hsync == 1'b0) ? 1 : 0;
      if (ifC.frame_tick) begin
        if (c_last >= 0) begin
          chk("C_frame_period", cyc - c_last, 1377);
          chk("C_vsync_act_per_frame", c_vs, 162);
        end
        c_last = cyc; c_vs = 0;
      end
      c_vs += (ifC.vsync == 1'b1) ? 1 : 0;
    end
    chk("A_hsync_low_per_line", hs_lo, 384);
    chk("A_ptick_per_line", pt_cnt, 800);
    chk("A_vid_per_line", vid_cnt, 2560);
    chk("A_rgb_fff_per_line", fff_cnt, 2560);
    chk("B_ptick_constant", b_pt, 3200);

    t = 0;
    while (ifA.x != 10'd300 && t < 4000) begin @(negedge clk); t++; end
    chk("A_reach_x300", int'(ifA.x), 300);
    rst_n[0] = 1'b0;
    @(negedge clk);
    chk("A_midrst_x", int'(ifA.x), 799);
    chk("A_midrst_y", int'(ifA.y), 524);
    chk("A_midrst_hsync", int'(ifA.hsync), 1);
    chk("A_midrst_rgb", int'(ifA.vga_rgb), 0);
    rst_n[0] = 1'b1;

    t = 0;
    while (!(ifC.x == 10'd23 && ifC.y == 10'd6) && t < 3000) begin @(negedge clk); t++; end
    chk("C_reach_23_6", int'({ifC.x, ifC.y}), (23 << 10) | 6);
    chk("C_pre_rst_hsync", int'(ifC.hsync), 1);
    rst_n[2] = 1'b0;
    @(negedge clk);
    chk("C_midrst_xy", int'({ifC.x, ifC.y}), (26 << 10) | 16);
    chk("C_midrst_hsync", int'(ifC.hsync), 0);
    chk("C_midrst_vid", int'(ifC.vid_on), 0);
    rst_n[2] = 1'b1;
    hs_lo = 0;
    repeat (30) begin
      @(negedge clk);
      hs_lo += int'(ifC.hsync);
    end
    chk("C_no_stale_hsync", hs_lo, 0);

    repeat (100) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
